// File: rtl/dvp_camera_sequencer.sv
// dvp_camera_sequencer
//   Power-up / reset sequencer for a DVP camera. It also generates the camera
//   master clock (XCLK) by dividing clk.
//
//   Parameters:
//     INTL_CLK_FREQ  clk frequency in Hz; documentation only
//     DVP_CAM_CFG_W  configuration word width (>= 16)
//     PWDN_WAIT_CYC  clk cycles spent in PWR_UP
//     RST_HOLD_CYC   clk cycles spent in RST_HOLD
//     RST_WAIT_CYC   clk cycles spent in RST_WAIT
//
//   Ports:
//     clk            single clock
//     rst            synchronous active-high reset
//     dcr_cam_cfg_i  bit0 start, bit1 pwdn, bits[15:8] XCLK half divisor
//     dvp_xclk_o     camera master clock, period 2*half_div clk cycles
//     dvp_pwdn_o     camera power-down pin (high only in OFF)
//     dvp_rst_n_o    camera reset pin, active low
//     cam_ready_o    high when the camera is operational
//     cam_state_o    current sequencer state
//
//   Build option: define DVP_CAM_RST_SEQ_EN to include the RST_HOLD/RST_WAIT
//   hardware reset stage. When it is undefined, PWR_UP goes directly to READY.
//   In that build dvp_rst_n_o is low only while rst is asserted.
module dvp_camera_sequencer #(
    parameter int INTL_CLK_FREQ = 125000000,
    parameter int DVP_CAM_CFG_W = 32,
    parameter int PWDN_WAIT_CYC = 1024,
    parameter int RST_HOLD_CYC  = 256,
    parameter int RST_WAIT_CYC  = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DVP_CAM_CFG_W-1:0] dcr_cam_cfg_i,
    output logic                     dvp_xclk_o,
    output logic                     dvp_pwdn_o,
    output logic                     dvp_rst_n_o,
    output logic                     cam_ready_o,
    output logic [2:0]               cam_state_o
);

    localparam int MAX_WAIT_A = (PWDN_WAIT_CYC > RST_HOLD_CYC) ? PWDN_WAIT_CYC : RST_HOLD_CYC;
    localparam int MAX_WAIT   = (MAX_WAIT_A > RST_WAIT_CYC) ? MAX_WAIT_A : RST_WAIT_CYC;
    localparam int CNT_W      = $clog2(MAX_WAIT) + 1;

    localparam logic [CNT_W-1:0] PWDN_LAST = CNT_W'(PWDN_WAIT_CYC - 1);
`ifdef DVP_CAM_RST_SEQ_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
`endif
    localparam logic [DVP_CAM_CFG_W-1:0] CFG_USED = DVP_CAM_CFG_W'(32'h0000_FF03);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_PWR_UP   = 3'd1,
`ifdef DVP_CAM_RST_SEQ_EN
        ST_RST_HOLD = 3'd2,
        ST_RST_WAIT = 3'd3,
`endif
        ST_READY    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [7:0]       div_q, div_d;
    logic [7:0]       hd_q, hd_d;
    logic             xclk_q, xclk_d;
    logic             pwdn_q, pwdn_d;
    logic             rst_n_q, rst_n_d;
    logic             ready_q, ready_d;

    logic       run;
    logic [7:0] hd_in;
    logic       unused_cfg;

    assign run        = dcr_cam_cfg_i[0] & ~dcr_cam_cfg_i[1];
    assign hd_in      = (dcr_cam_cfg_i[15:8] == 8'd0) ? 8'd1 : dcr_cam_cfg_i[15:8];
    assign unused_cfg = ^(dcr_cam_cfg_i & ~CFG_USED);

    always_comb begin
        state_d = state_q;
        if (!run) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:      state_d = ST_PWR_UP;
`ifdef DVP_CAM_RST_SEQ_EN
                ST_PWR_UP:   if (phase_q == PWDN_LAST) state_d = ST_RST_HOLD;
                ST_RST_HOLD: if (phase_q == HOLD_LAST) state_d = ST_RST_WAIT;
                ST_RST_WAIT: if (phase_q == WAIT_LAST) state_d = ST_READY;
`else
                ST_PWR_UP:   if (phase_q == PWDN_LAST) state_d = ST_READY;
`endif
                ST_READY:    state_d = ST_READY;
                default:     state_d = ST_OFF;
            endcase
        end

        // The counter only matters in the timed states. It is held at 0 in OFF
        // and READY so that it cannot wrap.
        if (state_d != state_q || state_d == ST_OFF || state_d == ST_READY)
            phase_d = '0;
        else
            phase_d = phase_q + 1'b1;

        // XCLK divider. The divisor used for a half-period is the one latched
        // at the preceding wrap (or at OFF exit), so a change never truncates
        // the half-period in progress. While in OFF, hd is re-sampled every
        // cycle, which is equivalent to latching it at OFF exit.
        div_d  = div_q;
        hd_d   = hd_q;
        xclk_d = xclk_q;
        if (state_q == ST_OFF || state_d == ST_OFF) begin
            div_d  = '0;
            xclk_d = 1'b0;
            if (state_q == ST_OFF)
                hd_d = hd_in;
        end else if (div_q == hd_q - 8'd1) begin
            div_d  = '0;
            xclk_d = ~xclk_q;
            hd_d   = hd_in;
        end else begin
            div_d = div_q + 8'd1;
        end

        // Pin outputs are registered from the next state, so they line up
        // with cam_state_o.
        pwdn_d  = (state_d == ST_OFF);
        ready_d = (state_d == ST_READY);
`ifdef DVP_CAM_RST_SEQ_EN
        rst_n_d = !(state_d == ST_OFF || state_d == ST_RST_HOLD);
`else
        rst_n_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            phase_q <= '0;
            div_q   <= '0;
            hd_q    <= 8'd1;
            xclk_q  <= 1'b0;
            pwdn_q  <= 1'b1;
            rst_n_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            hd_q    <= hd_d;
            xclk_q  <= xclk_d;
            pwdn_q  <= pwdn_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
        end
    end

    assign dvp_xclk_o  = xclk_q;
    assign dvp_pwdn_o  = pwdn_q;
    assign dvp_rst_n_o = rst_n_q;
    assign cam_ready_o = ready_q;
    assign cam_state_o = state_q;

endmodule

// File: tb/tb_dvp_camera_sequencer.sv
// Directed testbench for dvp_camera_sequencer with short waits (4/3/5).
// The expected values depend on whether DVP_CAM_RST_SEQ_EN is defined.
module tb_dvp_camera_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] cfg;
    logic        xclk, pwdn, rst_n, ready;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    dvp_camera_sequencer #(
        .INTL_CLK_FREQ(125000000),
        .DVP_CAM_CFG_W(32),
        .PWDN_WAIT_CYC(4),
        .RST_HOLD_CYC (3),
        .RST_WAIT_CYC (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dcr_cam_cfg_i(cfg),
        .dvp_xclk_o   (xclk),
        .dvp_pwdn_o   (pwdn),
        .dvp_rst_n_o  (rst_n),
        .cam_ready_o  (ready),
        .cam_state_o  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_cfg(input logic start, input logic pd, input logic [7:0] hd);
        return {16'h0000, hd, 6'b000000, pd, start};
    endfunction

    // Advance one clock edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected state k cycles after leaving OFF with run=1 (waits 4/3/5).
    function automatic logic [2:0] exp_state(input int k);
`ifdef DVP_CAM_RST_SEQ_EN
        if (k <= 4)  return 3'd1;
        if (k <= 7)  return 3'd2;
        if (k <= 12) return 3'd3;
        return 3'd4;
`else
        if (k <= 4) return 3'd1;
        return 3'd4;
`endif
    endfunction

    function automatic logic exp_rst_n(input logic [2:0] s);
`ifdef DVP_CAM_RST_SEQ_EN
        return !(s == 3'd0 || s == 3'd2);
`else
        return s == s;
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL %s state: got %0d want 0", tag, state); end
        checks++;
        if (xclk !== 1'b0)  begin errors++; $display("FAIL %s xclk: got %b want 0", tag, xclk); end
        checks++;
        if (pwdn !== 1'b1)  begin errors++; $display("FAIL %s pwdn: got %b want 1", tag, pwdn); end
        checks++;
        if (rst_n !== 1'b0) begin errors++; $display("FAIL %s rst_n: got %b want 0", tag, rst_n); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL %s ready: got %b want 0", tag, ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg = mk_cfg(1'b1, 1'b0, 8'd2);
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
    endtask

    // Runs 16 cycles from the reset release, so the sequencer ends in READY
    // with xclk high.
    task automatic test_full_sequence();
        logic [2:0] es;
        logic       ex;
        for (int k = 1; k <= 16; k++) begin
            tick();
            es = exp_state(k);
            ex = logic'(((k - 1) / 2) % 2);
            checks++;
            if (state !== es) begin errors++; $display("FAIL seq_state k=%0d: got %0d want %0d", k, state, es); end
            checks++;
            if (xclk !== ex) begin errors++; $display("FAIL seq_xclk k=%0d: got %b want %b", k, xclk, ex); end
            checks++;
            if (ready !== (es == 3'd4)) begin errors++; $display("FAIL seq_ready k=%0d: got %b want %b", k, ready, es == 3'd4); end
            checks++;
            if (pwdn !== 1'b0) begin errors++; $display("FAIL seq_pwdn k=%0d: got %b want 0", k, pwdn); end
            checks++;
            if (rst_n !== exp_rst_n(es)) begin errors++; $display("FAIL seq_rst_n k=%0d: got %b want %b", k, rst_n, exp_rst_n(es)); end
        end
    endtask

    task automatic test_abort();
        logic erst;
        erst = exp_rst_n(3'd0);
        cfg = mk_cfg(1'b1, 1'b1, 8'd2);
        tick();
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", state); end
        checks++;
        if (pwdn !== 1'b1)  begin errors++; $display("FAIL abort_pwdn: got %b want 1", pwdn); end
        checks++;
        if (rst_n !== erst) begin errors++; $display("FAIL abort_rst_n: got %b want %b", rst_n, erst); end
        checks++;
        if (xclk !== 1'b0)  begin errors++; $display("FAIL abort_xclk: got %b want 0", xclk); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", ready); end
        tick();
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL abort_hold_state: got %0d want 0", state); end
    endtask

    task automatic test_zero_divisor();
        logic ex;
        for (int h = 0; h <= 1; h++) begin
            cfg = mk_cfg(1'b0, 1'b0, 8'd0);
            tick();
            cfg = mk_cfg(1'b1, 1'b0, 8'(h));
            for (int k = 1; k <= 8; k++) begin
                tick();
                ex = logic'((k - 1) % 2);
                checks++;
                if (xclk !== ex) begin errors++; $display("FAIL zero_div hd=%0d k=%0d: got %b want %b", h, k, xclk, ex); end
            end
        end
    endtask

    // Set bits outside [15:8] and [1:0] to confirm that they are ignored.
    // hd=3 rises at k=4. The change to 5 lands mid half-period: xclk still
    // falls at k=7, then rises at 12 and falls at 17.
    task automatic test_divisor_change();
        logic ex;
        cfg = mk_cfg(1'b0, 1'b0, 8'd3);
        tick();
        cfg = {16'hA5A5, 8'd3, 6'b111111, 2'b01};
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 5) cfg = {16'h5A5A, 8'd5, 6'b101010, 2'b01};
            if (k < 4)       ex = 1'b0;
            else if (k < 7)  ex = 1'b1;
            else if (k < 12) ex = 1'b0;
            else if (k < 17) ex = 1'b1;
            else             ex = 1'b0;
            checks++;
            if (xclk !== ex) begin errors++; $display("FAIL div_change k=%0d: got %b want %b", k, xclk, ex); end
        end
        checks++;
        if (state !== exp_state(18)) begin errors++; $display("FAIL div_change_state: got %0d want %0d", state, exp_state(18)); end
    endtask

    task automatic test_reset_mid_sequence();
        int stop_k;
`ifdef DVP_CAM_RST_SEQ_EN
        stop_k = 6;
`else
        stop_k = 2;
`endif
        cfg = mk_cfg(1'b0, 1'b0, 8'd2);
        tick();
        cfg = mk_cfg(1'b1, 1'b0, 8'd2);
        for (int k = 1; k <= stop_k; k++) tick();
        checks++;
        if (state !== exp_state(stop_k)) begin errors++; $display("FAIL midrst_pre: got %0d want %0d", state, exp_state(stop_k)); end
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        tick();
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL midrst_k1: got %0d want 1", state); end
        checks++;
        if (xclk !== 1'b0) begin errors++; $display("FAIL midrst_xclk_k1: got %b want 0", xclk); end
        for (int k = 2; k <= 5; k++) tick();
        checks++;
        if (state !== exp_state(5)) begin errors++; $display("FAIL midrst_k5: got %0d want %0d", state, exp_state(5)); end
        checks++;
        if (rst_n !== exp_rst_n(exp_state(5))) begin errors++; $display("FAIL midrst_rst_n_k5: got %b want %b", rst_n, exp_rst_n(exp_state(5))); end
    endtask

    initial begin
        rst = 1'b1;
        cfg = '0;
        test_reset();
        test_full_sequence();
        test_abort();
        test_zero_divisor();
        test_divisor_change();
        test_reset_mid_sequence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
